// File: rtl/mem_req_master.sv
// Command-FIFO fronted memory request master: queues host commands and issues
// them one at a time to a single-outstanding memory port with a response timeout.
module mem_req_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  wr_done,
    output logic                  err,
    output logic                  busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    logic [EW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [TW-1:0] r_tcnt;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_fifo[r_rptr];
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

    // Storage needs no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifo[r_wptr] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            mem_valid <= 1'b0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            err       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {mem_wr_rd, mem_addr, mem_wdata} <= w_head;
                        mem_valid <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_valid <= 1'b0;
                    r_tcnt    <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                        if (mem_wr_rd) begin
                            wr_done <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= mem_rdata;
                        end
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        // Give up on this command; it is not retried.
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: behavioural memory responder plus a command-level
// schedule model predicting every issue/response pulse and its cycle.
module tb_mem_req_master;

    localparam int W   = 16;
    localparam int D   = 64;
    localparam int AW  = 6;
    localparam int FD  = 4;
    localparam int TO  = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr_rd;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          mem_valid;
    logic          mem_wr_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ready;
    logic [W-1:0]  mem_rdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          wr_done;
    logic          err;
    logic          busy;

    mem_req_master #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
        .err(err), .busy(busy)
    );

    typedef struct {
        int          kind;   // 0 issue, 1 read response, 2 write done, 3 error
        int          cyc;
        logic [15:0] data;
        logic [22:0] aux;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    ev_t         keep_q[$];
    int          pop_q[$];
    logic [15:0] tb_mem [D];
    logic [15:0] model_mem [D];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          last_d = 0;
    bit          hold_off = 0;
    bit          spur = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Memory: answers one cycle after it samples mem_valid unless held off.
    initial begin
        bit          pend;
        bit          w;
        logic [5:0]  a;
        logic [15:0] d;
        mem_ready = 0;
        mem_rdata = '0;
        for (int i = 0; i < D; i++) tb_mem[i] = '0;
        forever begin
            @(negedge clk);
            pend = mem_valid && !hold_off && !rst;
            w = mem_wr_rd;
            a = mem_addr;
            d = mem_wdata;
            @(posedge clk);
            #1;
            if (pend) begin
                mem_ready = 1;
                if (w) begin
                    tb_mem[a] = d;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = tb_mem[a];
                end
            end else if (spur) begin
                mem_ready = 1;
                mem_rdata = 16'($urandom);
                spur = 0;
            end else begin
                mem_ready = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_valid) obs_q.push_back('{0, cyc, 16'h0, {mem_wr_rd, mem_addr, mem_wdata}});
            if (rsp_valid) obs_q.push_back('{1, cyc, rsp_rdata, {mem_wr_rd, mem_addr, mem_wdata}});
            if (wr_done)   obs_q.push_back('{2, cyc, 16'h0, {mem_wr_rd, mem_addr, mem_wdata}});
            if (err)       obs_q.push_back('{3, cyc, 16'h0, {mem_wr_rd, mem_addr, mem_wdata}});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int pops_before(input int e);
        int n = 0;
        foreach (pop_q[i]) if (pop_q[i] < e) n++;
        return n;
    endfunction

    // Offer one command; the model decides on which edge it is taken and
    // when it issues and completes.
    task automatic push_cmd(input bit wr, input logic [5:0] a, input logic [15:0] d, input bit to);
        int e;
        int p;
        int dd;
        bit rdy;
        cmd_valid = 1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e = cyc + 1;
            rdy = (n_acc - pops_before(e)) < FD;
            check("cmd_ready", 64'(cmd_ready), 64'(rdy));
            @(posedge clk);
            #1;
            if (rdy) begin
                n_acc++;
                p = (e + 1 > last_d + 1) ? e + 1 : last_d + 1;
                dd = to ? p + 1 + TO : p + 2;
                last_d = dd;
                pop_q.push_back(p);
                exp_q.push_back('{0, p, 16'h0, {wr, a, d}});
                if (to) begin
                    exp_q.push_back('{3, dd, 16'h0, {wr, a, d}});
                end else if (wr) begin
                    model_mem[a] = d;
                    exp_q.push_back('{2, dd, 16'h0, {wr, a, d}});
                end else begin
                    exp_q.push_back('{1, dd, model_mem[a], {wr, a, d}});
                end
                return;
            end
        end
        check("accept_bound", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        cmd_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the model's last completion, then the block must be idle.
    task automatic drain(input string tag);
        cmd_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 300 && cyc < last_d; k++) @(negedge clk);
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, " events"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " kind"}, 64'(obs_q[i].kind), 64'(exp_q[i].kind));
            check({tag, " cycle"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
            check({tag, " data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
            check({tag, " cmd"}, 64'(obs_q[i].aux), 64'(exp_q[i].aux));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " mem_valid"}, 64'(mem_valid), 64'(0));
        check({tag, " mem_wr_rd"}, 64'(mem_wr_rd), 64'(0));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({tag, " wr_done"}, 64'(wr_done), 64'(0));
        check({tag, " err"}, 64'(err), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        int r;
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        rst = 1;
        cmd_valid = 0;
        cmd_wr_rd = 0;
        cmd_addr = '0;
        cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk);
        #1;
        rst = 0;
        last_d = cyc;
        @(negedge clk);
        check_quiet("after_reset");
        @(posedge clk);
        #1;

        // Write then read the same word; read completes 3 edges after accept.
        push_cmd(1, 6'd5, 16'hA5A5, 0);
        drain("wr5");
        push_cmd(0, 6'd5, 16'h0000, 0);
        drain("rd5");
        compare_events("wr_rd_5");

        // Top address, an untouched word, then the top address again.
        push_cmd(1, 6'd63, 16'h3C5A, 0);
        push_cmd(0, 6'd0, 16'h1111, 0);
        push_cmd(0, 6'd63, 16'h2222, 0);
        drain("wrap");
        compare_events("wrap");

        // Hold cmd_valid through a burst long enough to fill the FIFO.
        for (int i = 0; i < 8; i++) push_cmd(i[0], 6'(10 + i), 16'(16'h1000 + i), 0);
        drain("burst");
        compare_events("burst");

        for (int i = 0; i < 24; i++) begin
            push_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom), 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        drain("random");
        compare_events("random");

        hold_off = 1;
        push_cmd(0, 6'd20, 16'hDEAD, 1);
        drain("timeout");
        hold_off = 0;
        compare_events("timeout");
        push_cmd(0, 6'd63, 16'h0, 0);
        drain("post_timeout");
        compare_events("post_timeout");

        @(negedge clk);
        spur = 1;
        idle(6);
        compare_events("spurious");
        push_cmd(0, 6'd5, 16'h0, 0);
        drain("post_spurious");
        compare_events("post_spurious");

        // One command stuck in WAIT, three queued, then reset with a write offered.
        hold_off = 1;
        push_cmd(0, 6'd1, 16'h0, 1);
        push_cmd(0, 6'd2, 16'h0, 0);
        push_cmd(0, 6'd3, 16'h0, 0);
        push_cmd(0, 6'd4, 16'h0, 0);
        cmd_valid = 1;
        cmd_wr_rd = 1;
        cmd_addr  = 6'd7;
        cmd_wdata = 16'hBEEF;
        rst = 1;
        @(posedge clk);
        #1;
        r = cyc;
        rst = 0;
        cmd_valid = 0;
        hold_off = 0;
        foreach (exp_q[i]) if (exp_q[i].cyc < r) keep_q.push_back(exp_q[i]);
        exp_q = keep_q;
        n_acc = 0;
        pop_q.delete();
        last_d = r;
        @(negedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1;
        idle(14);
        compare_events("reset_abandon");
        push_cmd(0, 6'd7, 16'h0, 0);
        drain("post_reset");
        compare_events("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
